uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 72 +++++++
 rtl/uart_tx_buffered.sv | 150 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered 8N1 UART transmitter.
package uart_pkg;

   // Transmit FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   // 8N1 frame: start bit, eight data bits, stop bit.
   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = DATA_BITS + 2;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo.sv
// Write buffer for the UART transmitter: circular storage with occupancy count.
// Full/empty come from the count alone; pointers wrap naturally (DEPTH is a power of two).
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = DATA_BITS
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wr_en_i,
   input  logic [DATA_W-1:0]          wr_data_i,
   input  logic                       rd_en_i,
   output logic [DATA_W-1:0]          rd_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              push, pop;

   assign full_o    = (count_q == CNT_FULL);
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   // A write while full is dropped outright, even if a pop happens in the same cycle.
   assign push = wr_en_i && !full_o;
   assign pop  = rd_en_i && !empty_o;

   // Next pointer and occupancy values; simultaneous push and pop leave count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Control state: pointers and count, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are meaningless until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule : uart_tx_fifo

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: write FIFO feeding a registered serial shifter.
// Frames go out back to back with no idle gap while the FIFO has data.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 19200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    tx_data_in,
   input  logic                          wr_en,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          tx,
   output logic                          tx_active,
   output logic                          done_tx
);

   localparam int CLK_DIVIDE = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W      = (CLK_DIVIDE > 1) ? $clog2(CLK_DIVIDE) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIVIDE - 1);
   localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
   localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic             pop;
   logic             baud_end;
   logic [7:0]       head;

   uart_tx_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (8)
   ) u_fifo (
      .clk_i     (clk),
      .rst_ni    (rst),
      .wr_en_i   (wr_en),
      .wr_data_i (tx_data_in),
      .rd_en_i   (pop),
      .rd_data_o (head),
      .full_o    (full),
      .empty_o   (empty),
      .count_o   (count)
   );

   assign baud_end  = (baud_q == BAUD_LAST);
   assign tx        = tx_q;
   assign tx_active = (state_q != IDLE);
   assign done_tx   = done_q;

   // Frame sequencing: each bit lasts CLK_DIVIDE clocks; the stop bit chains straight
   // into the next start bit when more data is queued.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               tx_d    = 1'b0;
               baud_d  = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == LAST_BIT) begin
                  bit_d   = '0;
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               done_d = 1'b1;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_ONE;
            end
         end
         default: begin
            tx_d    = 1'b1;
            baud_d  = '0;
            bit_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Transmitter registers; reset drops any frame in flight and returns the line high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

endmodule : uart_tx_buffered

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a line monitor decodes frames from tx, and each test
// compares the decoded bytes and timing against what the written data implies.
module tb_uart_tx_buffered;

   localparam int CLK_FREQ   = 1000000;
   localparam int BAUD_RATE  = 100000;
   localparam int FIFO_DEPTH = 8;
   localparam int CW         = $clog2(FIFO_DEPTH) + 1;
   localparam int BITT       = CLK_FREQ / BAUD_RATE;   // clocks per bit
   localparam int FRAME      = 10 * BITT;              // clocks per 8N1 frame

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [7:0]    tx_data_in = 8'h00;
   logic          full, empty, tx, tx_active, done_tx;
   logic [CW-1:0] count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] rx_q[$];
   int         start_q[$];
   int         done_q[$];
   int         bad_frames = 0;
   int         active_cycles = 0;
   logic [9:0] mon_bits;
   logic       mon_ok, mon_ab;
   int         mon_t0;

   uart_tx_buffered #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data_in (tx_data_in),
      .wr_en      (wr_en),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .tx         (tx),
      .tx_active  (tx_active),
      .done_tx    (done_tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done_tx === 1'b1) done_q.push_back(cyc);
      if (tx_active === 1'b1) active_cycles <= active_cycles + 1;
   end

   // Line monitor: on a falling tx, sample every cycle of ten bit periods.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && tx === 1'b0) begin
            mon_t0 = cyc;
            mon_ok = 1'b1;
            mon_ab = 1'b0;
            for (int b = 0; b < 10; b++) begin
               for (int s = 0; s < BITT; s++) begin
                  if (b != 0 || s != 0) @(negedge clk);
                  if (rst !== 1'b1) mon_ab = 1'b1;
                  if (s == 0) mon_bits[b] = tx;
                  else if (tx !== mon_bits[b]) mon_ok = 1'b0;
               end
            end
            if (!mon_ab) begin
               start_q.push_back(mon_t0);
               rx_q.push_back(mon_bits[8:1]);
               if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1 || !mon_ok)
                  bad_frames = bad_frames + 1;
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_write(input logic [7:0] b);
      wr_en = 1'b1;
      tx_data_in = b;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(empty === 1'b1 && tx_active === 1'b0) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles (empty=%b active=%b)", n, empty, tx_active);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({tx, tx_active, done_tx, empty, full, count} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, CW'(0)}) begin
         errors++;
         $display("FAIL reset_outputs: got %b want %b", {tx, tx_active, done_tx, empty, full, count},
                  {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, CW'(0)});
      end
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if ({tx, tx_active, done_tx, empty, full, count} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, CW'(0)}) begin
         errors++;
         $display("FAIL idle_after_reset: got %b want %b", {tx, tx_active, done_tx, empty, full, count},
                  {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, CW'(0)});
      end
   endtask

   task automatic test_single();
      int s0 = start_q.size();
      int r0 = rx_q.size();
      int d0 = done_q.size();
      int a0 = active_cycles;
      int cw;
      do_write(8'hA5);
      cw = cyc;
      checks++;
      if ({empty, count} !== {1'b0, CW'(1)}) begin
         errors++;
         $display("FAIL single_after_write: empty/count got %b/%0d want 0/1", empty, count);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({tx, tx_active, count} !== {1'b0, 1'b1, CW'(0)}) begin
         errors++;
         $display("FAIL single_pop: tx/active/count got %b/%b/%0d want 0/1/0", tx, tx_active, count);
      end
      wait_idle(400);
      settle();
      checks++;
      if (rx_q.size() != r0 + 1) begin
         errors++;
         $display("FAIL single_frames: got %0d want %0d", rx_q.size() - r0, 1);
      end
      checks++;
      if (rx_q[r0] !== 8'hA5) begin
         errors++;
         $display("FAIL single_byte: got %h want a5", rx_q[r0]);
      end
      checks++;
      if (start_q[s0] != cw + 1) begin
         errors++;
         $display("FAIL single_latency: start at %0d want %0d", start_q[s0], cw + 1);
      end
      checks++;
      if (done_q.size() != d0 + 1 || done_q[d0] - start_q[s0] != FRAME) begin
         errors++;
         $display("FAIL single_done: pulses %0d offset %0d want 1 and %0d", done_q.size() - d0,
                  done_q[d0] - start_q[s0], FRAME);
      end
      checks++;
      if (active_cycles - a0 != FRAME) begin
         errors++;
         $display("FAIL single_active: got %0d cycles want %0d", active_cycles - a0, FRAME);
      end
      checks++;
      if (bad_frames != 0) begin
         errors++;
         $display("FAIL single_framing: bad frames got %0d want 0", bad_frames);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v[3];
      int s0 = start_q.size();
      int r0 = rx_q.size();
      int d0 = done_q.size();
      int a0 = active_cycles;
      v[0] = 8'h00; v[1] = 8'hFF; v[2] = 8'h3C;
      for (int i = 0; i < 3; i++) do_write(v[i]);
      wait_idle(700);
      settle();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rx_q[r0 + i] !== v[i]) begin
            errors++;
            $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[r0 + i], v[i]);
         end
      end
      for (int i = 1; i < 3; i++) begin
         checks++;
         if (start_q[s0 + i] - start_q[s0 + i - 1] != FRAME) begin
            errors++;
            $display("FAIL b2b_gap%0d: got %0d want %0d", i, start_q[s0 + i] - start_q[s0 + i - 1], FRAME);
         end
         checks++;
         if (done_q[d0 + i] - done_q[d0 + i - 1] != FRAME) begin
            errors++;
            $display("FAIL b2b_done%0d: got %0d want %0d", i, done_q[d0 + i] - done_q[d0 + i - 1], FRAME);
         end
      end
      checks++;
      if (done_q.size() - d0 != 3 || rx_q.size() - r0 != 3) begin
         errors++;
         $display("FAIL b2b_counts: done %0d frames %0d want 3 and 3", done_q.size() - d0, rx_q.size() - r0);
      end
      checks++;
      if (active_cycles - a0 != 3 * FRAME) begin
         errors++;
         $display("FAIL b2b_active: got %0d want %0d", active_cycles - a0, 3 * FRAME);
      end
   endtask

   task automatic test_fill();
      logic [7:0] v[12];
      int r0 = rx_q.size();
      int d0 = done_q.size();
      for (int i = 0; i < 12; i++) v[i] = 8'($urandom);
      wr_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tx_data_in = v[i];
         @(posedge clk);
         #1;
      end
      wr_en = 1'b0;
      checks++;
      if ({full, count} !== {1'b1, CW'(FIFO_DEPTH)}) begin
         errors++;
         $display("FAIL fill_full: full/count got %b/%0d want 1/%0d", full, count, FIFO_DEPTH);
      end
      wait_idle(12 * FRAME);
      settle();
      checks++;
      if (rx_q.size() - r0 != FIFO_DEPTH + 1 || done_q.size() - d0 != FIFO_DEPTH + 1) begin
         errors++;
         $display("FAIL fill_frames: frames %0d done %0d want %0d", rx_q.size() - r0, done_q.size() - d0,
                  FIFO_DEPTH + 1);
      end
      for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
         checks++;
         if (rx_q[r0 + i] !== v[i]) begin
            errors++;
            $display("FAIL fill_byte%0d: got %h want %h", i, rx_q[r0 + i], v[i]);
         end
      end
   endtask

   task automatic test_push_pop();
      logic [7:0] v[5];
      int r0 = rx_q.size();
      for (int i = 0; i < 5; i++) v[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) do_write(v[i]);
      checks++;
      if (count !== CW'(3)) begin
         errors++;
         $display("FAIL pp_count_before: got %0d want 3", count);
      end
      // first pop was one edge after the first write; the next pop is one frame later
      repeat (FRAME - 3) @(posedge clk);
      #1;
      checks++;
      if ({count, tx_active} !== {CW'(3), 1'b1}) begin
         errors++;
         $display("FAIL pp_pre_edge: count/active got %0d/%b want 3/1", count, tx_active);
      end
      do_write(v[4]);
      checks++;
      if ({count, tx} !== {CW'(3), 1'b0}) begin
         errors++;
         $display("FAIL pp_same_cycle: count/tx got %0d/%b want 3/0", count, tx);
      end
      wait_idle(8 * FRAME);
      settle();
      checks++;
      if (rx_q.size() - r0 != 5) begin
         errors++;
         $display("FAIL pp_frames: got %0d want 5", rx_q.size() - r0);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rx_q[r0 + i] !== v[i]) begin
            errors++;
            $display("FAIL pp_byte%0d: got %h want %h", i, rx_q[r0 + i], v[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         logic [7:0] exp_q[$];
         int r0 = rx_q.size();
         int n = $urandom_range(1, FIFO_DEPTH);
         for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            int gap;
            b = 8'($urandom);
            do_write(b);
            exp_q.push_back(b);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
               @(posedge clk);
               #1;
            end
         end
         wait_idle((n + 2) * FRAME);
         settle();
         checks++;
         if (rx_q.size() - r0 != n) begin
            errors++;
            $display("FAIL rand%0d_frames: got %0d want %0d", r, rx_q.size() - r0, n);
         end
         for (int i = 0; i < n; i++) begin
            checks++;
            if (rx_q[r0 + i] !== exp_q[i]) begin
               errors++;
               $display("FAIL rand%0d_byte%0d: got %h want %h", r, i, rx_q[r0 + i], exp_q[i]);
            end
         end
      end
      checks++;
      if (bad_frames != 0) begin
         errors++;
         $display("FAIL rand_framing: bad frames got %0d want 0", bad_frames);
      end
   endtask

   task automatic test_reset_midframe();
      int s0 = start_q.size();
      int d0 = done_q.size();
      int r0;
      int c0;
      int n = 0;
      do_write(8'($urandom));
      c0 = cyc + 1;
      do_write(8'($urandom));
      do_write(8'($urandom));
      // frame cycle 54 lies inside data bit 4
      while (cyc < c0 + 54 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({tx, tx_active, done_tx, empty, full, count} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, CW'(0)}) begin
         errors++;
         $display("FAIL midreset_async: got %b want %b", {tx, tx_active, done_tx, empty, full, count},
                  {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, CW'(0)});
      end
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      repeat (150) @(posedge clk);
      #1;
      checks++;
      if (start_q.size() != s0 || done_q.size() != d0) begin
         errors++;
         $display("FAIL midreset_quiet: frames %0d done %0d want 0 and 0", start_q.size() - s0, done_q.size() - d0);
      end
      checks++;
      if ({tx, empty} !== 2'b11) begin
         errors++;
         $display("FAIL midreset_idle: tx/empty got %b/%b want 1/1", tx, empty);
      end
      r0 = rx_q.size();
      do_write(8'h55);
      wait_idle(400);
      settle();
      checks++;
      if (rx_q.size() != r0 + 1 || rx_q[r0] !== 8'h55) begin
         errors++;
         $display("FAIL midreset_resume: frames %0d byte %h want 1 and 55", rx_q.size() - r0, rx_q[r0]);
      end
      checks++;
      if (done_q.size() != d0 + 1) begin
         errors++;
         $display("FAIL midreset_done: got %0d want 1", done_q.size() - d0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fill();
      test_push_pop();
      test_random();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_uart_tx_buffered
